// File: rtl/boton_control.sv
// Four-button press classifier: times the hold of the highest-priority new press
// and reports one short/long event per press through a valid/ack handshake.
module boton_control #(
    parameter int LONG_TIME = 2000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_i,
    input  logic       evt_ack_i,
    output logic       evt_valid_o,
    output logic [1:0] evt_btn_o,
    output logic       evt_long_o,
    output logic       busy_o
);

    localparam int CW = $clog2(LONG_TIME + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LONG_TIME - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPORT,
        RELEASE
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      btn_prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            long_q, long_d;
    logic [3:0]      rise;
    logic [1:0]      rise_idx;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        rise     = btn_i & ~btn_prev_q;
        rise_idx = 2'd0;
        if (rise[0])      rise_idx = 2'd0;
        else if (rise[1]) rise_idx = 2'd1;
        else if (rise[2]) rise_idx = 2'd2;
        else if (rise[3]) rise_idx = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        long_d  = long_q;
        case (state_q)
            IDLE: begin
                if (rise != 4'b0000) begin
                    sel_d   = rise_idx;
                    cnt_d   = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Release wins over the long threshold when both land in the same cycle.
                if (!btn_i[sel_q]) begin
                    long_d  = 1'b0;
                    state_d = REPORT;
                end else if (cnt_q == CNT_LAST) begin
                    long_d  = 1'b1;
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            REPORT: begin
                if (evt_ack_i) begin
                    state_d = (btn_i != 4'b0000) ? RELEASE : IDLE;
                end
            end
            RELEASE: begin
                if (btn_i == 4'b0000) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            btn_prev_q <= 4'b0000;
            cnt_q      <= '0;
            sel_q      <= 2'd0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_prev_q <= btn_i;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            long_q     <= long_d;
        end
    end

    assign evt_valid_o = (state_q == REPORT);
    assign evt_btn_o   = evt_valid_o ? sel_q : 2'd0;
    assign evt_long_o  = evt_valid_o ? long_q : 1'b0;
    assign busy_o      = (state_q == HOLD);

endmodule

// File: tb/tb_boton_control.sv
// Self-checking bench for boton_control with LONG_TIME=4: directed scenarios plus
// randomized presses checked against a press-duration arithmetic model.
module tb_boton_control;

    localparam int LT = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic       evt_ack;
    logic       evt_valid;
    logic [1:0] evt_btn;
    logic       evt_long;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    boton_control #(.LONG_TIME(LT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_i      (btn),
        .evt_ack_i  (evt_ack),
        .evt_valid_o(evt_valid),
        .evt_btn_o  (evt_btn),
        .evt_long_o (evt_long),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {valid, btn[1:0], long, busy}.
    wire [4:0] outs = {evt_valid, evt_btn, evt_long, busy};
    localparam logic [4:0] V_IDLE = 5'b0_00_0_0;
    localparam logic [4:0] V_BUSY = 5'b0_00_0_1;

    function automatic logic [4:0] v_evt(input int sel, input logic lng);
        return {1'b1, 2'(sel), lng, 1'b0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL reset_initial: got %b want %b", outs, V_IDLE); end
        btn = 4'b1111;
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL reset_held: got %b want %b", outs, V_IDLE); end
        btn = 4'b0000;
        cyc();
        rst_n = 1'b1;
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL reset_release: got %b want %b", outs, V_IDLE); end
    endtask

    task automatic test_short();
        evt_ack = 1'b1;
        btn = 4'b0001;
        cyc();
        n_tests++;
        if (outs !== V_BUSY) begin n_fail++; $display("FAIL short_busy: got %b want %b", outs, V_BUSY); end
        cyc();
        btn = 4'b0000;
        cyc();
        n_tests++;
        if (outs !== v_evt(0, 1'b0)) begin n_fail++; $display("FAIL short_event: got %b want %b", outs, v_evt(0, 1'b0)); end
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL short_one_cycle: got %b want %b", outs, V_IDLE); end
        evt_ack = 1'b0;
        cyc();
    endtask

    task automatic test_long();
        logic [4:0] e;
        evt_ack = 1'b1;
        btn = 4'b0100;
        cyc();
        for (int j = 1; j <= 9; j++) begin
            btn = (j >= 6) ? 4'b0101 : 4'b0100;
            cyc();
            e = (j < LT) ? V_BUSY : (j == LT) ? v_evt(2, 1'b1) : V_IDLE;
            n_tests++;
            if (outs !== e) begin n_fail++; $display("FAIL long_step%0d: got %b want %b", j, outs, e); end
        end
        btn = 4'b0000;
        evt_ack = 1'b0;
        cyc();
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL long_no_second: got %b want %b", outs, V_IDLE); end
    endtask

    task automatic test_simultaneous();
        evt_ack = 1'b0;
        btn = 4'b1010;
        cyc();
        n_tests++;
        if (outs !== V_BUSY) begin n_fail++; $display("FAIL simul_busy: got %b want %b", outs, V_BUSY); end
        cyc();
        cyc();
        btn = 4'b1000;
        cyc();
        n_tests++;
        if (outs !== v_evt(1, 1'b0)) begin n_fail++; $display("FAIL simul_event: got %b want %b", outs, v_evt(1, 1'b0)); end
        evt_ack = 1'b1;
        cyc();
        evt_ack = 1'b0;
        for (int j = 0; j < 4; j++) begin
            btn = (j < 2) ? 4'b1000 : 4'b0000;
            cyc();
            n_tests++;
            if (outs !== V_IDLE) begin n_fail++; $display("FAIL simul_ignored%0d: got %b want %b", j, outs, V_IDLE); end
        end
    endtask

    task automatic test_boundary();
        btn = 4'b0001;
        cyc();
        for (int j = 1; j < LT; j++) cyc();
        btn = 4'b0000;
        cyc();
        n_tests++;
        if (outs !== v_evt(0, 1'b0)) begin n_fail++; $display("FAIL boundary_short: got %b want %b", outs, v_evt(0, 1'b0)); end
        evt_ack = 1'b1;
        cyc();
        evt_ack = 1'b0;
        cyc();
    endtask

    task automatic test_backpressure();
        int bad = 0;
        btn = 4'b0001;
        cyc();
        cyc();
        btn = 4'b0000;
        cyc();
        evt_ack = 1'b0;
        for (int j = 0; j < 20; j++) begin
            btn = {3'($urandom), 1'b0};
            cyc();
            n_tests++;
            if (outs !== v_evt(0, 1'b0)) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got %b want %b", j, outs, v_evt(0, 1'b0));
            end
        end
        evt_ack = 1'b1;
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL backpressure_ack: got %b want %b", outs, V_IDLE); end
        evt_ack = 1'b0;
        btn = 4'b0000;
        cyc();
        cyc();
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] e;
        btn = 4'b0001;
        cyc();
        cyc();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL rst_mid_hold_async: got %b want %b", outs, V_IDLE); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            cyc();
            e = (t < 5) ? V_BUSY : v_evt(0, 1'b1);
            n_tests++;
            if (outs !== e) begin n_fail++; $display("FAIL rst_new_press%0d: got %b want %b", t, outs, e); end
        end
        evt_ack = 1'b1;
        btn = 4'b0000;
        cyc();
        n_tests++;
        if (outs !== V_IDLE) begin n_fail++; $display("FAIL rst_new_ack: got %b want %b", outs, V_IDLE); end
        evt_ack = 1'b0;
        cyc();
    endtask

    // Model: a press held for k sampled cycles reports at min(k, LT) edges after the rise,
    // and is long exactly when it is still held at the LT-th edge (k > LT).
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            int         sel   = $urandom_range(0, 3);
            int         k     = $urandom_range(1, 2 * LT + 1);
            int         d     = $urandom_range(0, 3);
            int         t_evt = (k < LT) ? k : LT;
            logic       lng   = (k > LT);
            logic [4:0] e;
            btn = 4'b0001 << sel;
            evt_ack = 1'($urandom);
            cyc();
            n_tests++;
            if (outs !== V_BUSY) begin n_fail++; $display("FAIL rand%0d_start: got %b want %b", it, outs, V_BUSY); end
            for (int j = 1; j <= t_evt; j++) begin
                btn = 4'($urandom);
                btn[sel] = (j < k);
                evt_ack = 1'($urandom);
                cyc();
                e = (j < t_evt) ? V_BUSY : v_evt(sel, lng);
                n_tests++;
                if (outs !== e) begin n_fail++; $display("FAIL rand%0d_hold%0d (sel=%0d k=%0d): got %b want %b", it, j, sel, k, outs, e); end
            end
            for (int j = 0; j < d; j++) begin
                btn = 4'($urandom);
                evt_ack = 1'b0;
                cyc();
                n_tests++;
                if (outs !== v_evt(sel, lng)) begin n_fail++; $display("FAIL rand%0d_stall%0d: got %b want %b", it, j, outs, v_evt(sel, lng)); end
            end
            btn = 4'($urandom);
            evt_ack = 1'b1;
            cyc();
            n_tests++;
            if (outs !== V_IDLE) begin n_fail++; $display("FAIL rand%0d_ack: got %b want %b", it, outs, V_IDLE); end
            evt_ack = 1'b0;
            btn = 4'b0000;
            cyc();
            cyc();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        btn     = 4'b0000;
        evt_ack = 1'b0;
        test_reset();
        test_short();
        test_long();
        test_simultaneous();
        test_boundary();
        test_backpressure();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boton_control.md
BOTON_CONTROL -- requirements
Module: boton_control

Interface
REQ-001 Parameter LONG_TIME, default 2000: hold duration in clk cycles that separates a short press from a long press; legal range >= 2.
REQ-002 clk  input  1  system clock (1 ms period in the product).
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 btn  input  4  debounced button levels, 1 = pressed, synchronous to clk.
REQ-005 evt_ack  input  1  consumer accepts the pending event.
REQ-006 evt_valid  output  1  event pending.
REQ-007 evt_btn  output  2  index of the button that caused the event.
REQ-008 evt_long  output  1  1 = long press, 0 = short press.
REQ-009 busy  output  1  a press is currently being timed.

Function
REQ-010 The block SHALL register btn each cycle into btn_prev and SHALL define rise = btn & ~btn_prev.
REQ-011 The FSM SHALL have exactly four states: IDLE, HOLD, REPORT and RELEASE.
REQ-012 In IDLE, when rise != 0, the FSM SHALL do all of the following:
- latch sel = lowest set index of rise (btn[0] has highest priority);
- clear the hold counter;
- go to HOLD on the next cycle.
REQ-013 In IDLE, when rise == 0, the FSM SHALL remain in IDLE.
REQ-014 In HOLD with btn[sel]=1 and counter < LONG_TIME-1, the counter SHALL increment by 1.
REQ-015 In HOLD with btn[sel]=1 and counter == LONG_TIME-1, the FSM SHALL go to REPORT with evt_long=1.
REQ-016 In HOLD with btn[sel]=0, the FSM SHALL go to REPORT with evt_long=0, including in the cycle where counter == LONG_TIME-1.
REQ-017 The counter SHALL be $clog2(LONG_TIME+1) bits wide and SHALL never wrap.
REQ-018 Rises on other buttons while in HOLD, REPORT or RELEASE SHALL be ignored; they are not queued.
REQ-019 In REPORT:
- evt_valid SHALL be 1;
- evt_btn = sel;
- evt_long SHALL hold its latched value;
- all three SHALL stay stable until evt_ack is sampled 1.
REQ-020 When evt_ack=1 is sampled in REPORT, evt_valid SHALL be 0 from the next cycle.
REQ-021 On that REPORT exit, the FSM SHALL go to RELEASE if btn != 0, otherwise to IDLE.
REQ-022 In RELEASE, the FSM SHALL go to IDLE in the first cycle with btn == 0.
REQ-023 evt_ack SHALL be ignored outside REPORT.
REQ-024 busy SHALL be 1 exactly while the state is HOLD.
REQ-025 Timing SHALL be as follows, taking the cycle in which the rise is sampled in IDLE as cycle T:
- a long event SHALL assert evt_valid at cycle T+LONG_TIME+1;
- a short event SHALL assert evt_valid one cycle after the release is sampled in HOLD.
REQ-026 evt_btn and evt_long SHALL be driven 0 whenever evt_valid=0.

Reset
REQ-027 While rst=0, the block SHALL be forced into the following state, asynchronously:
- FSM = IDLE;
- btn_prev = 0, counter = 0, sel = 0;
- evt_valid = 0, evt_btn = 0, evt_long = 0, busy = 0.
REQ-028 Reset asserted mid-HOLD or mid-REPORT SHALL discard the press or event with no event output.
REQ-029 Because btn_prev resets to 0, a button held through reset release SHALL be treated as a new press in the first cycle after reset release.

Verification (LONG_TIME=4)
REQ-030 Short press:
- stimulus: btn=0001 for 2 cycles, then 0000;
- response: evt_valid=1, evt_btn=0, evt_long=0;
- with evt_ack held 1: evt_valid=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-031 Long press:
- stimulus: btn=0100 held for 10 cycles, evt_ack=1;
- response: evt_valid at T+5 with evt_btn=2, evt_long=1;
- then RELEASE until btn=0000;
- no second event.
REQ-032 Simultaneous rise:
- stimulus: btn 0000 -> 1010 in one cycle;
- response: evt_btn=1;
- the button-3 press is ignored, with no event even after button 1 is released.
REQ-033 Boundary:
- stimulus: btn[0] released in exactly the cycle where counter == 3;
- response: evt_long=0.
REQ-034 Backpressure:
- stimulus: evt_ack held 0 for 20 cycles while the other buttons toggle;
- response: evt_valid, evt_btn and evt_long stay constant;
- a single ack clears evt_valid on the next cycle.
REQ-035 Reset mid-HOLD:
- stimulus: rst=0 for 1 cycle while btn=0001 is held;
- response: all outputs 0 immediately;
- after reset release with the button still held, a new press is timed, with evt_long=1 at release+5.
